// File: rtl/regfile_mp_pkg.sv
// Shared CPU constants: default register-file geometry and the hardwired-zero register index.
package regfile_mp_pkg;

  localparam int unsigned DataW   = 32;
  localparam int unsigned AddrW   = 5;
  localparam int unsigned NumRd   = 2;
  localparam int unsigned RegZero = 0;

endpackage

// File: rtl/regfile_rdport.sv
// One read port: array mux with same-cycle write bypass and scoreboard busy lookup.
module regfile_rdport
  import regfile_mp_pkg::*;
#(
  parameter int unsigned DATA_W = DataW,
  parameter int unsigned ADDR_W = AddrW
) (
  input  logic                   Reset,
  input  logic [ADDR_W-1:0]      RA,
  input  logic [DATA_W-1:0]      Regs [2**ADDR_W],
  input  logic [2**ADDR_W-1:0]   Busy,
  input  logic                   WrAct0,
  input  logic [ADDR_W-1:0]      WA0,
  input  logic [DATA_W-1:0]      WD0,
  input  logic                   WrAct1,
  input  logic [ADDR_W-1:0]      WA1,
  input  logic [DATA_W-1:0]      WD1,
  output logic [DATA_W-1:0]      RD,
  output logic                   RBusy
);

  logic hit0;
  logic hit1;

  // WrAct already excludes register 0, so a hit never targets the zero register.
  assign hit0 = WrAct0 && (WA0 == RA);
  assign hit1 = WrAct1 && (WA1 == RA);

  // Bypass port 1 over port 0 over the array; everything forced low while in reset.
  always_comb begin
    RD    = '0;
    RBusy = 1'b0;
    if (Reset) begin
      if (hit1) begin
        RD = WD1;
      end else if (hit0) begin
        RD = WD0;
      end else begin
        RD = Regs[RA];
      end
      // A write landing this cycle retires the pending result, so it is no longer busy.
      RBusy = Busy[RA] && !hit0 && !hit1 && (RA != ADDR_W'(RegZero));
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-ported register file: two write ports, NRD bypassed read ports, busy scoreboard.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int unsigned DATA_W = DataW,
  parameter int unsigned ADDR_W = AddrW,
  parameter int unsigned NRD    = NumRd
) (
  input  logic                  CLK,
  input  logic                  Reset,
  input  logic                  WE0,
  input  logic [ADDR_W-1:0]     WA0,
  input  logic [DATA_W-1:0]     WD0,
  input  logic                  WE1,
  input  logic [ADDR_W-1:0]     WA1,
  input  logic [DATA_W-1:0]     WD1,
  input  logic [NRD*ADDR_W-1:0] RA,
  output logic [NRD*DATA_W-1:0] RD,
  output logic [NRD-1:0]        RBusy,
  input  logic                  IssueEn,
  input  logic [ADDR_W-1:0]     IssueReg,
  input  logic                  Flush
);

  localparam int unsigned Depth = 2**ADDR_W;

  logic [DATA_W-1:0] regsQ [Depth];
  logic [Depth-1:0]  busyQ;
  logic [Depth-1:0]  busyD;
  logic              wrAct0;
  logic              wrAct1;
  logic              issueAct;

  assign wrAct0   = WE0 && (WA0 != ADDR_W'(RegZero));
  assign wrAct1   = WE1 && (WA1 != ADDR_W'(RegZero));
  assign issueAct = IssueEn && (IssueReg != ADDR_W'(RegZero));

  // Data array; port 1 is assigned last so it wins on an address collision.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < int'(Depth); i++) begin
        regsQ[i] <= '0;
      end
    end else begin
      if (wrAct0) begin
        regsQ[WA0] <= WD0;
      end
      if (wrAct1) begin
        regsQ[WA1] <= WD1;
      end
    end
  end

  // Scoreboard next state: flush clears everything, otherwise writes clear and issue sets.
  always_comb begin
    busyD = busyQ;
    if (Flush) begin
      busyD = '0;
    end else begin
      if (wrAct0) begin
        busyD[WA0] = 1'b0;
      end
      if (wrAct1) begin
        busyD[WA1] = 1'b0;
      end
      if (issueAct) begin
        busyD[IssueReg] = 1'b1;
      end
    end
    busyD[RegZero] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      busyQ <= '0;
    end else begin
      busyQ <= busyD;
    end
  end

  for (genvar k = 0; k < int'(NRD); k++) begin : gRd
    regfile_rdport #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
    ) uRdPort (
      .Reset  (Reset),
      .RA     (RA[k*ADDR_W +: ADDR_W]),
      .Regs   (regsQ),
      .Busy   (busyQ),
      .WrAct0 (wrAct0),
      .WA0    (WA0),
      .WD0    (WD0),
      .WrAct1 (wrAct1),
      .WA1    (WA1),
      .WD1    (WD1),
      .RD     (RD[k*DATA_W +: DATA_W]),
      .RBusy  (RBusy[k])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed vector table, reset and wide-port sequences,
// then random traffic compared against an array-based reference model.
module tb_regfile_mp;

  logic        CLK;
  logic        Reset;
  logic        WE0, WE1, IssueEn, Flush;
  logic [4:0]  WA0, WA1, IssueReg;
  logic [31:0] WD0, WD1;
  logic [9:0]  RA;
  logic [63:0] RD;
  logic [1:0]  RBusy;

  // Second build: four read ports, 16 registers.
  logic        we0B, we1B, issueB, flushB;
  logic [3:0]  wa0B, wa1B, issueRegB;
  logic [31:0] wd0B, wd1B;
  logic [15:0] raB;
  logic [127:0] rdB;
  logic [3:0]  rBusyB;

  int nChecks = 0;
  int nErrors = 0;

  // Reference model state.
  logic [31:0] mMem [32];
  bit          mBusy [32];

  // Field order: rstn we0 wa0 wd0 we1 wa1 wd1 ie ir fl ra0 ra1 | rd0 rd1 rb0 rb1
  typedef struct {
    logic [31:0] rstn, we0, wa0, wd0, we1, wa1, wd1, ie, ir, fl, ra0, ra1;
    logic [31:0] rd0, rd1, rb0, rb1;
  } vec_t;

  localparam int NVec = 20;
  vec_t vecs [NVec];

  regfile_mp #(
    .DATA_W (32),
    .ADDR_W (5),
    .NRD    (2)
  ) uDut (
    .CLK      (CLK),
    .Reset    (Reset),
    .WE0      (WE0),
    .WA0      (WA0),
    .WD0      (WD0),
    .WE1      (WE1),
    .WA1      (WA1),
    .WD1      (WD1),
    .RA       (RA),
    .RD       (RD),
    .RBusy    (RBusy),
    .IssueEn  (IssueEn),
    .IssueReg (IssueReg),
    .Flush    (Flush)
  );

  regfile_mp #(
    .DATA_W (32),
    .ADDR_W (4),
    .NRD    (4)
  ) uDut4 (
    .CLK      (CLK),
    .Reset    (Reset),
    .WE0      (we0B),
    .WA0      (wa0B),
    .WD0      (wd0B),
    .WE1      (we1B),
    .WA1      (wa1B),
    .WD1      (wd1B),
    .RA       (raB),
    .RD       (rdB),
    .RBusy    (rBusyB),
    .IssueEn  (issueB),
    .IssueReg (issueRegB),
    .Flush    (flushB)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  function automatic bit writesTo(input logic [4:0] a);
    return (WE0 && WA0 == a) || (WE1 && WA1 == a);
  endfunction

  function automatic logic [31:0] expRd(input logic [4:0] a);
    if (!Reset || a == 5'd0) return 32'h0;
    if (WE1 && WA1 == a) return WD1;
    if (WE0 && WA0 == a) return WD0;
    return mMem[a];
  endfunction

  function automatic logic [31:0] expRb(input logic [4:0] a);
    if (!Reset || a == 5'd0) return 32'h0;
    return {31'h0, mBusy[a] && !writesTo(a)};
  endfunction

  task automatic modelClear();
    for (int i = 0; i < 32; i++) begin
      mMem[i]  = 32'h0;
      mBusy[i] = 1'b0;
    end
  endtask

  // What a rising edge does to the architectural state.
  task automatic modelEdge();
    if (!Reset) return;
    if (WE0 && WA0 != 5'd0) mMem[WA0] = WD0;
    if (WE1 && WA1 != 5'd0) mMem[WA1] = WD1;
    if (Flush) begin
      for (int i = 0; i < 32; i++) mBusy[i] = 1'b0;
    end else begin
      if (WE0 && WA0 != 5'd0) mBusy[WA0] = 1'b0;
      if (WE1 && WA1 != 5'd0) mBusy[WA1] = 1'b0;
      if (IssueEn && IssueReg != 5'd0) mBusy[IssueReg] = 1'b1;
    end
  endtask

  task automatic drive(input vec_t v);
    Reset    = v.rstn[0];
    WE0      = v.we0[0];
    WA0      = v.wa0[4:0];
    WD0      = v.wd0;
    WE1      = v.we1[0];
    WA1      = v.wa1[4:0];
    WD1      = v.wd1;
    IssueEn  = v.ie[0];
    IssueReg = v.ir[4:0];
    Flush    = v.fl[0];
    RA       = {v.ra1[4:0], v.ra0[4:0]};
    if (!Reset) modelClear();
  endtask

  task automatic idle(input logic [4:0] ra0, input logic [4:0] ra1);
    vec_t v;
    v = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, ra0, ra1, 0, 0, 0, 0};
    drive(v);
  endtask

  function automatic logic [4:0] rndAddr();
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, 7));
  endfunction

  initial begin
    vec_t v;

    vecs[0]  = '{1, 1, 3, 'hAAAA, 1, 3, 'h5555, 0, 0, 0, 3, 0, 'h5555, 0, 0, 0};
    vecs[1]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 'h5555, 0, 0, 0};
    vecs[2]  = '{1, 1, 0, 'hFFFFFFFF, 0, 0, 0, 1, 0, 0, 0, 3, 0, 'h5555, 0, 0};
    vecs[3]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 'h5555, 0, 0};
    vecs[4]  = '{1, 0, 0, 0, 0, 0, 0, 1, 7, 0, 7, 0, 0, 0, 0, 0};
    vecs[5]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 0, 0, 0, 1, 0};
    vecs[6]  = '{1, 1, 7, 'h42, 0, 0, 0, 0, 0, 0, 7, 0, 'h42, 0, 0, 0};
    vecs[7]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 7, 'h42, 'h42, 0, 0};
    vecs[8]  = '{1, 0, 0, 0, 1, 9, 'h99, 1, 9, 0, 9, 0, 'h99, 0, 0, 0};
    vecs[9]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 9, 0, 'h99, 0, 1, 0};
    vecs[10] = '{1, 0, 0, 0, 0, 0, 0, 1, 9, 1, 9, 9, 'h99, 'h99, 1, 1};
    vecs[11] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 9, 0, 'h99, 0, 0, 0};
    vecs[12] = '{1, 1, 5, 'h1234, 0, 0, 0, 0, 0, 0, 0, 5, 0, 'h1234, 0, 0};
    vecs[13] = '{1, 0, 0, 0, 1, 6, 'h66, 1, 6, 1, 6, 5, 'h66, 'h1234, 0, 0};
    vecs[14] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6, 5, 'h66, 'h1234, 0, 0};
    vecs[15] = '{1, 1, 10, 'hA0, 1, 11, 'hB1, 0, 0, 0, 10, 11, 'hA0, 'hB1, 0, 0};
    vecs[16] = '{1, 0, 0, 0, 0, 0, 0, 1, 12, 0, 12, 0, 0, 0, 0, 0};
    vecs[17] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 12, 12, 0, 0, 1, 1};
    vecs[18] = '{1, 1, 12, 'h11, 1, 12, 'h22, 0, 0, 0, 12, 0, 'h22, 0, 0, 0};
    vecs[19] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 12, 12, 'h22, 'h22, 0, 0};

    we0B = 0; we1B = 0; issueB = 0; flushB = 0;
    wa0B = 0; wa1B = 0; issueRegB = 0; wd0B = 0; wd1B = 0; raB = 0;

    // Reset state, with active-looking inputs that must be ignored.
    v = '{0, 1, 3, 'hDEAD, 1, 4, 'hBEEF, 1, 3, 0, 3, 4, 0, 0, 0, 0};
    drive(v);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    #2;
    chk("reset_rd0", RD[31:0], 32'h0);
    chk("reset_rd1", RD[63:32], 32'h0);
    chk("reset_rbusy", {30'h0, RBusy}, 32'h0);
    @(negedge CLK);
    idle(3, 4);
    #2;
    chk("post_reset_r3", RD[31:0], 32'h0);
    chk("post_reset_r4", RD[63:32], 32'h0);

    // Directed vector table.
    for (int i = 0; i < NVec; i++) begin
      @(negedge CLK);
      drive(vecs[i]);
      #2;
      chk($sformatf("vec%0d_rd0", i), RD[31:0], vecs[i].rd0);
      chk($sformatf("vec%0d_rd1", i), RD[63:32], vecs[i].rd1);
      chk($sformatf("vec%0d_rb0", i), {31'h0, RBusy[0]}, vecs[i].rb0);
      chk($sformatf("vec%0d_rb1", i), {31'h0, RBusy[1]}, vecs[i].rb1);
      @(posedge CLK);
      modelEdge();
    end

    // Mid-run reset: R5 holds 0x1234; a write issued during reset is lost.
    @(negedge CLK);
    idle(0, 5);
    #2;
    chk("pre_reset_r5", RD[63:32], 32'h1234);
    v = '{0, 1, 5, 'hFFFF, 0, 0, 0, 1, 5, 0, 0, 5, 0, 0, 0, 0};
    drive(v);
    #1;
    chk("midreset_r5", RD[63:32], 32'h0);
    chk("midreset_rbusy", {31'h0, RBusy[1]}, 32'h0);
    @(posedge CLK);
    @(negedge CLK);
    idle(9, 5);
    #2;
    chk("after_reset_r5", RD[63:32], 32'h0);
    chk("after_reset_r9", RD[31:0], 32'h0);
    chk("after_reset_busy", {31'h0, RBusy[1]}, 32'h0);
    // First edge after release must take a write.
    v = '{1, 1, 5, 'h77, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    drive(v);
    @(posedge CLK);
    modelEdge();
    @(negedge CLK);
    idle(5, 0);
    #2;
    chk("resume_write_r5", RD[31:0], 32'h77);

    // Four-port build: distinct writes then simultaneous reads of R1..R4.
    we0B = 1; wa0B = 4'd1; wd0B = 32'h11;
    we1B = 1; wa1B = 4'd2; wd1B = 32'h22;
    @(posedge CLK);
    @(negedge CLK);
    wa0B = 4'd3; wd0B = 32'h33;
    wa1B = 4'd4; wd1B = 32'h44;
    @(posedge CLK);
    @(negedge CLK);
    we0B = 0; we1B = 0;
    raB = {4'd4, 4'd3, 4'd2, 4'd1};
    #2;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("wide_port%0d", k), rdB[k*32 +: 32], 32'h11 * (k + 1));
    end
    chk("wide_rbusy", {28'h0, rBusyB}, 32'h0);

    // Random traffic against the reference model.
    for (int c = 0; c < 400; c++) begin
      @(negedge CLK);
      v.rstn = ($urandom_range(0, 49) != 0) ? 1 : 0;
      v.we0  = $urandom_range(0, 1);
      v.wa0  = 32'(rndAddr());
      v.wd0  = $urandom;
      v.we1  = $urandom_range(0, 1);
      v.wa1  = 32'(rndAddr());
      v.wd1  = $urandom;
      v.ie   = $urandom_range(0, 1);
      v.ir   = 32'(rndAddr());
      v.fl   = ($urandom_range(0, 15) == 0) ? 1 : 0;
      v.ra0  = 32'(rndAddr());
      v.ra1  = 32'(rndAddr());
      drive(v);
      #2;
      chk($sformatf("rnd%0d_rd0", c), RD[31:0], expRd(RA[4:0]));
      chk($sformatf("rnd%0d_rd1", c), RD[63:32], expRd(RA[9:5]));
      chk($sformatf("rnd%0d_rb0", c), {31'h0, RBusy[0]}, expRb(RA[4:0]));
      chk($sformatf("rnd%0d_rb1", c), {31'h0, RBusy[1]}, expRb(RA[9:5]));
      @(posedge CLK);
      modelEdge();
    end

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter DATA_W, 32, register width in bits.
REQ-002 SHALL have parameter ADDR_W, 5, address width; depth = 2**ADDR_W.
REQ-003 SHALL have parameter NRD, 2, number of read ports.
REQ-004 SHALL have port CLK  input  1  clock; all state updates on rising edge.
REQ-005 SHALL have port Reset  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port WE0  input  1  write port 0 enable.
REQ-007 SHALL have port WA0  input  ADDR_W  write port 0 address.
REQ-008 SHALL have port WD0  input  DATA_W  write port 0 data.
REQ-009 SHALL have port WE1  input  1  write port 1 enable.
REQ-010 SHALL have port WA1  input  ADDR_W  write port 1 address.
REQ-011 SHALL have port WD1  input  DATA_W  write port 1 data.
REQ-012 SHALL have port RA  input  NRD*ADDR_W  read addresses; port k at bits [k*ADDR_W +: ADDR_W].
REQ-013 SHALL have port RD  output  NRD*DATA_W  read data; port k at bits [k*DATA_W +: DATA_W].
REQ-014 SHALL have port RBusy  output  NRD  per-read-port scoreboard busy flag.
REQ-015 SHALL have port IssueEn  input  1  mark destination register busy.
REQ-016 SHALL have port IssueReg  input  ADDR_W  destination register being issued.
REQ-017 SHALL have port Flush  input  1  synchronous clear of all busy bits.

Function
REQ-018 SHALL hold register 0 at constant 0: writes ignored, reads return 0, never busy.
REQ-019 SHALL write WDn to register WAn on rising CLK when WEn=1 and WAn!=0.
REQ-020 SHALL, when WE0 and WE1 target the same nonzero address in one cycle, store WD1 (port 1 priority).
REQ-021 SHALL return read data combinationally (zero-cycle latency) from the array.
REQ-022 SHALL bypass: when RA[k] matches an active nonzero write address in the same cycle, RD[k] = that write data (WD1 over WD0).
REQ-023 SHALL set busy[IssueReg] on rising CLK when IssueEn=1 and IssueReg!=0.
REQ-024 SHALL clear busy[WAn] on rising CLK for every active write (WEn=1, WAn!=0).
REQ-025 SHALL, on simultaneous issue and write to the same register, leave busy=1 (set wins).
REQ-026 SHALL, when Flush=1, clear all busy bits that edge; Flush overrides IssueEn; data writes still proceed.
REQ-027 SHALL drive RBusy[k] = busy[RA[k]] AND NOT (a same-cycle active write to RA[k]); 0 for RA[k]=0.
REQ-028 SHALL produce no X on RD/RBusy for any address within 0..2**ADDR_W-1.

Reset
REQ-029 SHALL, while Reset=0, asynchronously clear all data registers and busy bits to 0.
REQ-030 SHALL, while Reset=0, drive RD=0 and RBusy=0 for all ports regardless of inputs; bypass disabled.
REQ-031 SHALL ignore writes, issues and flushes on any edge where Reset=0; a write in progress is lost.
REQ-032 SHALL resume normal operation on the first rising CLK after Reset deasserts.

Structure
REQ-033 SHALL take default widths (DATA_W, ADDR_W) and the register-0 index constant from the shared CPU package.
REQ-034 SHALL instantiate one sub-module, regfile_rdport (mux plus bypass for one read port), NRD times via generate.
REQ-035 SHALL keep the busy scoreboard as one 2**ADDR_W-bit vector inside regfile_mp.

Verification
REQ-036 Reset=0 mid-run after writing R5=0x1234 -> RD for R5 = 0 immediately; after release, R5 still reads 0.
REQ-037 WE0=1 WA0=3 WD0=0xAAAA and WE1=1 WA1=3 WD1=0x5555 same edge -> RA=3 reads 0x5555 that cycle (bypass) and after.
REQ-038 WE0=1 WA0=0 WD0=0xFFFFFFFF; IssueEn=1 IssueReg=0 -> RD for R0 = 0, RBusy = 0.
REQ-039 Issue R7, next cycle RA=7 -> RBusy=1; cycle with WE0=1 WA0=7 WD0=0x42 -> RBusy=0, RD=0x42 same cycle; later busy=0.
REQ-040 Issue R9 and write R9 same edge -> busy[9]=1 after edge; then Flush=1 with IssueEn=1 IssueReg=9 -> busy[9]=0.
REQ-041 NRD=4, ADDR_W=4 build: four ports read R1..R4 after distinct writes -> each returns its own value, no cross-port interference.
